// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between ALU writeback (requester 0)
// and memory-load writeback (requester 1). Round-robin or fixed priority grant,
// registered write port, and a per-register pending-write scoreboard for RAW
// hazard detection at issue.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req0_valid/dest/data       ALU write request
//   req0_ready                 grant to ALU (combinational)
//   req1_valid/dest/data       load write request
//   req1_ready                 grant to load (combinational)
//   rf_write_enable/dest_reg/write_data   registered register-file write port
//   issue_valid, issue_dest    issue stage allocates a destination register
//   chk_src1, chk_src2         source indices to check
//   hazard1, hazard2           pending bit of chk_src1/chk_src2 (combinational)
//   conflict_count             saturating count of cycles with both requests valid
module regfile_write_arbiter #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 2,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_dest,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_dest,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              rf_write_enable,
   output logic [ADDR_W-1:0] rf_dest_reg,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_dest,
   input  logic [ADDR_W-1:0] chk_src1,
   input  logic [ADDR_W-1:0] chk_src2,
   output logic              hazard1,
   output logic              hazard2,
   output logic [7:0]        conflict_count
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;
   localparam logic [7:0]  CNT_MAX  = 8'hFF;

   logic                last_grant;
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_next;
   logic                xfer0;
   logic                xfer1;
   logic                conflict;

   assign conflict = req0_valid && req1_valid;

   // Grant: on a conflict, fixed priority favours requester 0, round-robin
   // favours the requester opposite the last grant.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (conflict) begin
         if (FIXED_PRIO || last_grant) begin
            req0_ready = 1'b1;
         end else begin
            req1_ready = 1'b1;
         end
      end else begin
         req0_ready = req0_valid;
         req1_ready = req1_valid;
      end
   end

   assign xfer0 = req0_valid && req0_ready;
   assign xfer1 = req1_valid && req1_ready;

   // Scoreboard next state: a commit clears, a new issue sets; set is applied
   // last so the newer producer keeps ownership of a shared index.
   always_comb begin
      pending_next = pending;
      if (rf_write_enable) begin
         pending_next[rf_dest_reg] = 1'b0;
      end
      if (issue_valid) begin
         pending_next[issue_dest] = 1'b1;
      end
   end

   // Write port register, grant history and conflict counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write_enable <= 1'b0;
         rf_dest_reg     <= '0;
         rf_write_data   <= '0;
         last_grant      <= 1'b1;
         pending         <= '0;
         conflict_count  <= 8'd0;
      end else begin
         rf_write_enable <= xfer0 || xfer1;
         if (xfer0) begin
            rf_dest_reg   <= req0_dest;
            rf_write_data <= req0_data;
            last_grant    <= 1'b0;
         end else if (xfer1) begin
            rf_dest_reg   <= req1_dest;
            rf_write_data <= req1_data;
            last_grant    <= 1'b1;
         end
         pending <= pending_next;
         if (conflict && (conflict_count != CNT_MAX)) begin
            conflict_count <= conflict_count + 8'd1;
         end
      end
   end

   // Hazards come from registered state only; no same-cycle bypass.
   assign hazard1 = pending[chk_src1];
   assign hazard2 = pending[chk_src2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed bench: one round-robin instance (rr_*) and one fixed-priority
// instance (fx_*) driven with the same stimulus; expected values hand-computed.
module tb_regfile_write_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid, issue_valid;
   logic [1:0] req0_dest, req1_dest, issue_dest, chk_src1, chk_src2;
   logic [7:0] req0_data, req1_data;

   logic       rr_req0_ready, rr_req1_ready, rr_we, rr_hazard1, rr_hazard2;
   logic [1:0] rr_dest;
   logic [7:0] rr_data, rr_count;
   logic       fx_req0_ready, fx_req1_ready, fx_we, fx_hazard1, fx_hazard2;
   logic [1:0] fx_dest;
   logic [7:0] fx_data, fx_count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.DATA_W(8), .ADDR_W(2), .FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data),
      .req0_ready(rr_req0_ready),
      .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data),
      .req1_ready(rr_req1_ready),
      .rf_write_enable(rr_we), .rf_dest_reg(rr_dest), .rf_write_data(rr_data),
      .issue_valid(issue_valid), .issue_dest(issue_dest),
      .chk_src1(chk_src1), .chk_src2(chk_src2),
      .hazard1(rr_hazard1), .hazard2(rr_hazard2),
      .conflict_count(rr_count)
   );

   regfile_write_arbiter #(.DATA_W(8), .ADDR_W(2), .FIXED_PRIO(1'b1)) u_fx (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data),
      .req0_ready(fx_req0_ready),
      .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data),
      .req1_ready(fx_req1_ready),
      .rf_write_enable(fx_we), .rf_dest_reg(fx_dest), .rf_write_data(fx_data),
      .issue_valid(issue_valid), .issue_dest(issue_dest),
      .chk_src1(chk_src1), .chk_src2(chk_src2),
      .hazard1(fx_hazard1), .hazard2(fx_hazard2),
      .conflict_count(fx_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance past the next rising edge, then let combinational outputs settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_dest = 2'd0; req0_data = 8'h00;
      req1_valid = 1'b0; req1_dest = 2'd0; req1_data = 8'h00;
      issue_valid = 1'b0; issue_dest = 2'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      settle();
   endtask

   initial begin
      chk_src1 = 2'd0;
      chk_src2 = 2'd0;
      idle_inputs();

      // 1: reset state and a single ALU write
      do_reset();
      check("rst_we", rr_we, 0);
      check("rst_dest", rr_dest, 0);
      check("rst_data", rr_data, 0);
      check("rst_count", rr_count, 0);
      check("rst_hazard", rr_hazard1, 0);
      req0_valid = 1'b1; req0_dest = 2'd2; req0_data = 8'h5A;
      settle();
      check("t1_ready0", rr_req0_ready, 1);
      check("t1_ready1", rr_req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      check("t1_we", rr_we, 1);
      check("t1_dest", rr_dest, 2);
      check("t1_data", rr_data, 8'h5A);
      tick();
      check("t1_we_drop", rr_we, 0);

      // 2: round-robin conflict after reset
      do_reset();
      req0_valid = 1'b1; req0_dest = 2'd1; req0_data = 8'h11;
      req1_valid = 1'b1; req1_dest = 2'd3; req1_data = 8'h33;
      settle();
      check("t2_first_r0", rr_req0_ready, 1);
      check("t2_first_r1", rr_req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      settle();
      check("t2_we0", rr_we, 1);
      check("t2_dest0", rr_dest, 1);
      check("t2_data0", rr_data, 8'h11);
      check("t2_second_r1", rr_req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      check("t2_we1", rr_we, 1);
      check("t2_dest1", rr_dest, 3);
      check("t2_data1", rr_data, 8'h33);
      check("t2_count", rr_count, 1);
      tick();
      check("t2_we_drop", rr_we, 0);
      // last grant was req1: a held conflict alternates req0, req1
      req0_valid = 1'b1; req1_valid = 1'b1;
      settle();
      check("t2_alt_a", rr_req0_ready, 1);
      tick();
      check("t2_alt_b1", rr_req1_ready, 1);
      check("t2_alt_b0", rr_req0_ready, 0);
      tick();
      check("t2_alt_c", rr_req0_ready, 1);
      check("t2_alt_wdata", rr_data, 8'h33);
      idle_inputs();

      // 3: fixed priority starves req1 while req0 is held
      do_reset();
      req0_valid = 1'b1; req0_dest = 2'd0; req0_data = 8'hA0;
      req1_valid = 1'b1; req1_dest = 2'd3; req1_data = 8'hB3;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("t3_fx_r1_low", fx_req1_ready, 0);
         check("t3_fx_r0_high", fx_req0_ready, 1);
         tick();
      end
      req0_valid = 1'b0;
      settle();
      check("t3_fx_count", fx_count, 4);
      check("t3_fx_r1_grant", fx_req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      check("t3_fx_we", fx_we, 1);
      check("t3_fx_dest", fx_dest, 3);
      check("t3_fx_data", fx_data, 8'hB3);

      // 4: scoreboard set/clear and same-cycle priority
      do_reset();
      chk_src1 = 2'd2; chk_src2 = 2'd0;
      issue_valid = 1'b1; issue_dest = 2'd2;
      settle();
      check("t4_no_bypass", rr_hazard1, 0);
      tick();
      issue_valid = 1'b0;
      check("t4_set", rr_hazard1, 1);
      check("t4_fx_set", fx_hazard1, 1);
      check("t4_other", rr_hazard2, 0);
      req0_valid = 1'b1; req0_dest = 2'd2; req0_data = 8'h22;
      tick();
      req0_valid = 1'b0;
      check("t4_commit_we", rr_we, 1);
      check("t4_pending_during_we", rr_hazard1, 1);
      tick();
      check("t4_cleared", rr_hazard1, 0);
      // same-cycle set and clear on r2: set wins
      issue_valid = 1'b1; issue_dest = 2'd2;
      tick();
      issue_valid = 1'b0;
      req0_valid = 1'b1; req0_dest = 2'd2; req0_data = 8'h23;
      tick();
      req0_valid = 1'b0;
      issue_valid = 1'b1; issue_dest = 2'd2;
      check("t4_same_we", rr_we, 1);
      tick();
      issue_valid = 1'b0;
      check("t4_set_wins", rr_hazard1, 1);
      // different indices: commit r2 clears while issue r1 sets
      chk_src2 = 2'd1;
      req0_valid = 1'b1; req0_dest = 2'd2; req0_data = 8'h24;
      tick();
      req0_valid = 1'b0;
      issue_valid = 1'b1; issue_dest = 2'd1;
      tick();
      issue_valid = 1'b0;
      check("t4_diff_clear", rr_hazard1, 0);
      check("t4_diff_set", rr_hazard2, 1);
      check("t4_fx_diff_set", fx_hazard2, 1);

      // 5: reset on the cycle a transfer is accepted
      do_reset();
      chk_src2 = 2'd3;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h55; req1_data = 8'h66;
      issue_valid = 1'b1; issue_dest = 2'd3;
      tick();
      idle_inputs();
      settle();
      check("t5_pre_count", rr_count, 1);
      check("t5_pre_pending", rr_hazard2, 1);
      req0_valid = 1'b1; req0_dest = 2'd1; req0_data = 8'h77;
      reset = 1'b1;
      settle();
      check("t5_accept", rr_req0_ready, 1);
      tick();
      reset = 1'b0;
      req0_valid = 1'b0;
      check("t5_we_dropped", rr_we, 0);
      check("t5_count", rr_count, 0);
      check("t5_pending", rr_hazard2, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      settle();
      check("t5_grant_r0", rr_req0_ready, 1);
      check("t5_grant_r1", rr_req1_ready, 0);
      idle_inputs();

      // 6: conflict counter saturation, requesters hold valid
      do_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 254) check("t6_count_254", rr_count, 254);
         if (i == 255) check("t6_count_255", rr_count, 255);
         if (i == 256) check("t6_no_wrap", rr_count, 255);
      end
      check("t6_rr_final", rr_count, 255);
      check("t6_fx_final", fx_count, 255);
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
